// File: rtl/l2_access_arbiter_pkg.sv
// Shared constants for the L2 access arbiter: FSM encodings, port IDs and
// the saturating-counter helper used by the optional performance counters.
package l2_access_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_SAT) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/l2_arb_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the port that did not
// win last time is chosen; a lone request is always granted.
module l2_arb_rr_pick
    import l2_access_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1 ? PORT_D : PORT_I;
        end
    end

endmodule

// File: rtl/l2_access_arbiter.sv
// Shares the single L2 lookup port between L1-I (port 0) and L1-D (port 1),
// one access in flight. Optional hit/miss counters: define L2_ARB_PERF_CNT_EN.
module l2_access_arbiter
    import l2_access_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_hit,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    input  logic              l2_done,
    input  logic              l2_hit,
    input  logic [DATA_W-1:0] l2_rdata,
    output logic              busy,
    output logic              protocol_err,
    output logic [31:0]       l2_hit_count,
    output logic [31:0]       l2_miss_count
);

    // Handshake: a requester holds reqN (and addrN) high until it samples
    // rsp_validN=1, then drops req on that same edge. l2_req stays high with a
    // stable l2_addr until l2_done pulses; l2_hit/l2_rdata count only with it.
    logic [1:0]        state;
    logic              last_grant;
    logic              owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              hit_q;
    logic              perr_q;
    logic              grant_valid;
    logic              grant_id;

    l2_arb_rr_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= PORT_D;
            owner      <= PORT_I;
            addr_q     <= '0;
            data_q     <= '0;
            hit_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        addr_q     <= (grant_id == PORT_D) ? addr1 : addr0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (l2_done) begin
                        data_q <= l2_rdata;
                        hit_q  <= l2_hit;
                        state  <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            // A completion with nothing outstanding is a protocol violation.
            if (l2_done && state != ST_WAIT) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign l2_req       = (state == ST_WAIT);
    assign l2_addr      = addr_q;
    assign busy         = (state != ST_IDLE);
    assign rsp_valid0   = (state == ST_RESP) && (owner == PORT_I);
    assign rsp_valid1   = (state == ST_RESP) && (owner == PORT_D);
    assign rsp_data     = data_q;
    assign rsp_hit      = hit_q;
    assign protocol_err = perr_q;

`ifdef L2_ARB_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == ST_WAIT && l2_done) begin
            if (l2_hit) begin
                hit_cnt <= sat_inc(hit_cnt);
            end else begin
                miss_cnt <= sat_inc(miss_cnt);
            end
        end
    end

    assign l2_hit_count  = hit_cnt;
    assign l2_miss_count = miss_cnt;
`else
    assign l2_hit_count  = 32'd0;
    assign l2_miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_l2_access_arbiter.sv
// Randomized scoreboard bench for l2_access_arbiter; the bench plays both L1
// requesters and the L2, with a round-level arbitration model.
module tb_l2_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        rsp_valid0, rsp_valid1;
    logic [31:0] rsp_data;
    logic        rsp_hit;
    logic        l2_req;
    logic [31:0] l2_addr;
    logic        l2_done, l2_hit;
    logic [31:0] l2_rdata;
    logic        busy, protocol_err;
    logic [31:0] l2_hit_count, l2_miss_count;

    l2_access_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .addr0        (addr0),
        .req1         (req1),
        .addr1        (addr1),
        .rsp_valid0   (rsp_valid0),
        .rsp_valid1   (rsp_valid1),
        .rsp_data     (rsp_data),
        .rsp_hit      (rsp_hit),
        .l2_req       (l2_req),
        .l2_addr      (l2_addr),
        .l2_done      (l2_done),
        .l2_hit       (l2_hit),
        .l2_rdata     (l2_rdata),
        .busy         (busy),
        .protocol_err (protocol_err),
        .l2_hit_count (l2_hit_count),
        .l2_miss_count(l2_miss_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    // expected responses: {port, hit, data}
    logic [33:0] exp_q[$];
    logic        obs_ports[$];
    logic [33:0] mon_e;

    // reference model state
    logic        m_last;
    logic        m_pend[2];
    logic [31:0] m_addr[2];
    logic        m_perr;
    logic [31:0] m_hits, m_miss;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_last    = 1'b1;
        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;
        m_perr    = 1'b0;
        m_hits    = 32'd0;
        m_miss    = 32'd0;
        exp_q.delete();
    endtask

    // monitor: pops the scoreboard whenever a response strobe appears
    always @(negedge clk) begin
        if (rsp_valid0 || rsp_valid1) begin
            check("rsp_exclusive", 64'(rsp_valid0 & rsp_valid1), 64'd0);
            obs_ports.push_back(rsp_valid1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got v0=%0b v1=%0b required no strobe", rsp_valid0, rsp_valid1);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_port", 64'(rsp_valid1), 64'(mon_e[33]));
                check("rsp_hit", 64'(rsp_hit), 64'(mon_e[32]));
                check("rsp_data", 64'(rsp_data), 64'(mon_e[31:0]));
            end
        end
    end

    task automatic check_side();
        check("hit_count", 64'(l2_hit_count), 64'(m_hits));
        check("miss_count", 64'(l2_miss_count), 64'(m_miss));
        check("protocol_err", 64'(protocol_err), 64'(m_perr));
    endtask

    // One arbitration round, entered at a negedge with the arbiter idle.
    task automatic do_round(input logic new0, input logic new1, input logic [31:0] a0,
                            input logic [31:0] a1, input int lat, input logic hit,
                            input logic [31:0] data);
        logic        w;
        int          n;
        logic [31:0] exp_addr;
        if (new0 && !m_pend[0]) begin
            m_pend[0] = 1'b1; m_addr[0] = a0; addr0 = a0; req0 = 1'b1;
        end
        if (new1 && !m_pend[1]) begin
            m_pend[1] = 1'b1; m_addr[1] = a1; addr1 = a1; req1 = 1'b1;
        end
        if (!m_pend[0] && !m_pend[1]) return;
        w = (m_pend[0] && m_pend[1]) ? ~m_last : m_pend[1];
        m_last = w;
        exp_addr = m_addr[w];

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!l2_req && n < 20);
        check("l2_req_latency", 64'(n), 64'd1);
        check("l2_addr", 64'(l2_addr), 64'(exp_addr));
        // the owner's address moving during the access must not leak out
        if (w) addr1 = $urandom; else addr0 = $urandom;
        repeat (lat) begin
            @(negedge clk);
            check("l2_req_hold", 64'(l2_req), 64'd1);
            check("l2_addr_hold", 64'(l2_addr), 64'(exp_addr));
        end
        l2_done = 1'b1; l2_hit = hit; l2_rdata = data;
        exp_q.push_back({w, hit, data});
`ifdef L2_ARB_PERF_CNT_EN
        if (hit) m_hits = sat(m_hits); else m_miss = sat(m_miss);
`endif
        @(negedge clk);
        l2_done = 1'b0; l2_hit = 1'($urandom_range(0, 1)); l2_rdata = $urandom;
        check("rsp_strobe", 64'(w ? rsp_valid1 : rsp_valid0), 64'd1);
        check("rsp_other_low", 64'(w ? rsp_valid0 : rsp_valid1), 64'd0);
        if (w) req1 = 1'b0; else req0 = 1'b0;
        m_pend[w] = 1'b0;
        @(negedge clk);
        check("busy_idle", 64'(busy), 64'd0);
        check("l2_req_idle", 64'(l2_req), 64'd0);
        check("rsp_data_keep", 64'(rsp_data), 64'(data));
        check("rsp_hit_keep", 64'(rsp_hit), 64'(hit));
        check_side();
    endtask

    task automatic drain();
        while (m_pend[0] || m_pend[1]) begin
            do_round(1'b0, 1'b0, 32'd0, 32'd0, $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), $urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_l2_req"}, 64'(l2_req), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rsp_valid"}, 64'({rsp_valid1, rsp_valid0}), 64'd0);
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        check({tag, "_rsp_hit"}, 64'(rsp_hit), 64'd0);
        check({tag, "_l2_addr"}, 64'(l2_addr), 64'd0);
        check({tag, "_perr"}, 64'(protocol_err), 64'd0);
        check({tag, "_counts"}, {l2_hit_count, l2_miss_count}, 64'd0);
    endtask

    initial begin
        int n;
        logic [3:0] exp_order;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        l2_done = 1'b0; l2_hit = 1'b0; l2_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // first access: port 0 hit
        do_round(1'b1, 1'b0, 32'h0000_1A40, 32'd0, 3, 1'b1, 32'hDEAD_BEEF);

        // port 1 alone, miss
        do_round(1'b0, 1'b1, 32'd0, $urandom, 2, 1'b0, 32'h0000_0000);

        // completion pulse with nothing outstanding
        l2_done = 1'b1; l2_hit = 1'b1; l2_rdata = $urandom;
        m_perr = 1'b1;
        @(negedge clk);
        l2_done = 1'b0;
        repeat (3) @(negedge clk);
        check("perr_idle_busy", 64'(busy), 64'd0);
        check_side();
        do_round(1'b1, 1'b0, $urandom, 32'd0, 1, 1'b1, $urandom);
        check("perr_sticky", 64'(protocol_err), 64'd1);

        // reset while an access is outstanding
        req0 = 1'b1; addr0 = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!l2_req && n < 20);
        check("rst_test_l2_req", 64'(l2_req), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        check("midrst_quiet", 64'({l2_req, busy}), 64'd0);

        // both ports continuously requesting: strict alternation 0,1,0,1
        obs_ports.delete();
        do_round(1'b1, 1'b1, $urandom, $urandom, 1, 1'b1, $urandom);
        do_round(1'b1, 1'b1, $urandom, $urandom, 0, 1'b0, $urandom);
        do_round(1'b1, 1'b1, $urandom, $urandom, 2, 1'b1, $urandom);
        do_round(1'b1, 1'b1, $urandom, $urandom, 1, 1'b0, $urandom);
        exp_order = 4'b1010;
        check("fair_count", 64'(obs_ports.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs_ports.size(); i++) begin
            check("fair_order", 64'(obs_ports[i]), 64'(exp_order[i]));
        end
        drain();

        // randomized traffic
        for (int r = 0; r < 40; r++) begin
            logic n0, n1;
            n0 = 1'($urandom_range(0, 1));
            n1 = 1'($urandom_range(0, 1));
            if (!n0 && !n1 && !m_pend[0] && !m_pend[1]) n0 = 1'b1;
            do_round(n0, n1, $urandom, $urandom, $urandom_range(0, 4),
                     1'($urandom_range(0, 1)), $urandom);
        end
        drain();

`ifdef L2_ARB_PERF_CNT_EN
        // saturation of the hit counter
        force dut.hit_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.hit_cnt;
        m_hits = 32'hFFFF_FFFE;
        check("sat_preload", 64'(l2_hit_count), 64'(m_hits));
        for (int k = 0; k < 3; k++) begin
            do_round(1'b1, 1'b1, $urandom, $urandom, 1, 1'b1, $urandom);
        end
        drain();
        check("sat_final", 64'(l2_hit_count), 64'h0000_0000_FFFF_FFFF);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_access_arbiter.md
Name: l2_access_arbiter

Overview:
- Shares the single L2 lookup port of the two-level cache between two L1 miss paths: port 0 = L1-I, port 1 = L1-D.
- Accepts at most one outstanding L2 access at a time. Selects round-robin on contention, holds the L2 request stable until L2 completes, then returns data and hit/miss status to the owning requester.
- Sits between the L1 caches and the L2 inside the cache driver. Optionally keeps L2 hit/miss statistics.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data word width returned from L2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0  in  1  port 0 request level; held until rsp_valid0.
- addr0  in  ADDR_W  port 0 address; stable while req0 is high.
- req1  in  1  port 1 request level.
- addr1  in  ADDR_W  port 1 address.
- rsp_valid0  out  1  one-cycle response strobe to port 0.
- rsp_valid1  out  1  one-cycle response strobe to port 1.
- rsp_data  out  DATA_W  response data; valid when either strobe is high.
- rsp_hit  out  1  L2 hit flag for the response.
- l2_req  out  1  request to L2.
- l2_addr  out  ADDR_W  address to L2.
- l2_done  in  1  one-cycle completion pulse from L2.
- l2_hit  in  1  hit flag; qualified by l2_done.
- l2_rdata  in  DATA_W  read data; qualified by l2_done.
- busy  out  1  high whenever state != IDLE.
- protocol_err  out  1  sticky error flag.
- l2_hit_count  out  32  hit counter (optional feature).
- l2_miss_count  out  32  miss counter (optional feature).

Behaviour:
- Reset values: every output 0; state=IDLE; last_grant=1 (so port 0 wins the first tie); internal address, data and owner registers 0.
- Reset mid-operation: the outstanding L2 access is abandoned. l2_req is low in the cycle after the reset edge. No response is issued. L2 is reset by the same rst.
- State IDLE:
  - If req0|req1 is sampled high at an edge, latch owner and the owner's address, then go to WAIT.
  - Single request: grant that port.
  - Both requests: grant the port != last_grant, then set last_grant=owner.
- State WAIT:
  - l2_req=1 and l2_addr=latched address, both stable for the whole state. l2_req rises one cycle after the req edge.
  - Requester address changes during WAIT are ignored.
  - On l2_done: latch l2_rdata and l2_hit, then go to RESP.
  - No timeout; WAIT is held indefinitely.
- State RESP (exactly one cycle):
  - rsp_valid[owner]=1; rsp_data and rsp_hit driven from the latched values.
  - Next state is IDLE.
  - rsp_data and rsp_hit keep their last values outside RESP.
- Requester rule: drop req on the edge at which it samples rsp_valid=1. The arbiter therefore never re-grants a stale request.
- Latency:
  - req sampled -> l2_req high: 1 cycle.
  - l2_done sampled -> rsp_valid: 1 cycle.
  - Minimum request-to-request spacing: 3 cycles (plus the L2 time).
- Fairness: under continuous requests on both ports, grants strictly alternate 0,1,0,1…
- Error handling:
  - l2_done in IDLE or RESP sets protocol_err (sticky until rst). The pulse is otherwise ignored.
  - A req dropped in WAIT before rsp_valid does not abort the access; the response is still strobed.
- Both rsp_valid strobes are never high in the same cycle.

Optional Feature:
- Macro: L2_ARB_PERF_CNT_EN.
- Defined:
  - On each l2_done accepted in WAIT, increment l2_hit_count if l2_hit=1, else increment l2_miss_count.
  - Each counter saturates at 32'hFFFF_FFFF.
  - Counters are cleared by rst.
- Undefined: both count outputs are tied to 0, and no counter flops are instantiated.

Decomposition:
- Shared package/header:
  - State encodings: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Port ID constants: PORT_I=1'b0, PORT_D=1'b1.
  - Counter saturation constant.
- One sub-module, l2_arb_rr_pick: combinational 2-way round-robin picker (inputs req0, req1, last_grant; outputs grant_valid, grant_id). Reused by future multi-requester arbiters.

Test Plan:
- Reset then req0=1, addr0=32'h0000_1A40; L2 returns l2_done 3 cycles after l2_req with l2_hit=1, l2_rdata=32'hDEAD_BEEF -> l2_addr=32'h0000_1A40 one cycle after the req edge; rsp_valid0 for one cycle with rsp_data=32'hDEAD_BEEF, rsp_hit=1; hit_count=1 when enabled.
- req0 and req1 raised in the same cycle, held per protocol, 4 back-to-back rounds -> grant order 0,1,0,1; never both rsp_valid strobes high.
- Only req1 active, with a miss response (l2_hit=0, l2_rdata=32'h0000_0000) -> rsp_valid1 with rsp_hit=0; miss_count increments by 1; last_grant=1.
- Inject l2_done while in IDLE -> protocol_err=1 and stays 1; no rsp_valid; the next normal transaction still completes.
- Assert rst in WAIT, 2 cycles after l2_req -> l2_req=0, busy=0, all outputs at reset values the cycle after reset; no response strobe.
- With L2_ARB_PERF_CNT_EN defined, counter preloaded via force to 32'hFFFF_FFFE, then 3 hits -> l2_hit_count ends at 32'hFFFF_FFFF. Without the macro, both counters read 0 throughout.
